// File: rtl/matrix_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix-multiply write-back path.
//   state_t          : collector FSM states (IDLE, WRITE)
//   DEF_CORE_COUNT   : default cores per tile (lanes written per tile)
//   DEF_DATA_W       : default width of one result element
//   MATRIX_ADDR_W    : result-memory address width, shared with the
//                      address sequencer
//   lane_sel_w()     : width of a lane index for a given core count
//   tile_base()      : row*s_cols + core_column at full precision
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int DEF_CORE_COUNT = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int MATRIX_ADDR_W  = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  function automatic int lane_sel_w(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

  // 5-bit row * 8-bit column count + 5-bit column fits in 14 bits; callers
  // truncate to the memory address width, which gives the modulo wrap.
  function automatic logic [13:0] tile_base(input logic [4:0] row,
                                            input logic [4:0] col,
                                            input logic [7:0] s_cols);
    return ({9'd0, row} * {6'd0, s_cols}) + {9'd0, col};
  endfunction

endpackage

// File: rtl/matrix_result_collector_if.sv
// ---------------------------------------------------------------------------
// matrix_result_collector_if
// Tile-delivery and result-memory write bundle of the collector.
//   Tile side   : i_f_matrix_row_size, i_s_matrix_column_size, i_row_adr,
//                 i_core_column, i_results_valid, i_results
//   Memory side : i_wr_ready, o_wr_en, o_wr_adr, o_wr_data
//   Status      : o_busy, o_done, o_overflow, o_written_count, o_checksum
// Modports: master = the environment (drives i_*), slave = the collector.
// ---------------------------------------------------------------------------
interface matrix_result_collector_if #(
  parameter int CORE_COUNT = matrix_pkg::DEF_CORE_COUNT,
  parameter int DATA_W     = matrix_pkg::DEF_DATA_W,
  parameter int ADDR_W     = matrix_pkg::MATRIX_ADDR_W
);

  logic [7:0]                   i_f_matrix_row_size;
  logic [7:0]                   i_s_matrix_column_size;
  logic [4:0]                   i_row_adr;
  logic [4:0]                   i_core_column;
  logic                         i_results_valid;
  logic [CORE_COUNT*DATA_W-1:0] i_results;
  logic                         i_wr_ready;
  logic                         o_wr_en;
  logic [ADDR_W-1:0]            o_wr_adr;
  logic [DATA_W-1:0]            o_wr_data;
  logic                         o_busy;
  logic                         o_done;
  logic                         o_overflow;
  logic [15:0]                  o_written_count;
  logic [DATA_W-1:0]            o_checksum;

  modport master (
    output i_f_matrix_row_size, i_s_matrix_column_size, i_row_adr,
           i_core_column, i_results_valid, i_results, i_wr_ready,
    input  o_wr_en, o_wr_adr, o_wr_data, o_busy, o_done, o_overflow,
           o_written_count, o_checksum
  );

  modport slave (
    input  i_f_matrix_row_size, i_s_matrix_column_size, i_row_adr,
           i_core_column, i_results_valid, i_results, i_wr_ready,
    output o_wr_en, o_wr_adr, o_wr_data, o_busy, o_done, o_overflow,
           o_written_count, o_checksum
  );

endinterface

// File: rtl/matrix_result_collector_lane_select.sv
// ---------------------------------------------------------------------------
// matrix_lane_select
// Combinational mux returning lane `sel` of a packed tile.
//   lanes : CORE_COUNT*DATA_W packed tile, lane k at [k*DATA_W +: DATA_W]
//   sel   : lane index
//   lane  : selected element (zero for an index past the last lane)
// ---------------------------------------------------------------------------
module matrix_lane_select
  import matrix_pkg::*;
#(
  parameter int CORE_COUNT = DEF_CORE_COUNT,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SEL_W      = lane_sel_w(CORE_COUNT)
) (
  input  logic [CORE_COUNT*DATA_W-1:0] lanes,
  input  logic [SEL_W-1:0]             sel,
  output logic [DATA_W-1:0]            lane
);

  always_comb begin
    // NOTE: default first so every path assigns lane and no latch is inferred.
    lane = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (32'(sel) == i) lane = lanes[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/matrix_result_collector.sv
// ---------------------------------------------------------------------------
// matrix_result_collector
// Drains one (row, core_column) tile of dot-product results into result
// memory, one element per cycle behind a ready handshake, tracks completion
// of the whole result matrix and flags tile strobes that arrive while busy.
//   CLOCK_25 : system clock, rising edge
//   rst      : asynchronous, active-low reset
//   bus      : matrix_result_collector_if.slave (tile input, memory write
//              port, status)
// Optional feature: define MATRIX_COLLECT_CHECKSUM_EN to accumulate every
// accepted write into o_checksum; otherwise o_checksum is tied to zero.
// ---------------------------------------------------------------------------
module matrix_result_collector
  import matrix_pkg::*;
#(
  parameter int CORE_COUNT = DEF_CORE_COUNT,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = MATRIX_ADDR_W
) (
  input logic                    CLOCK_25,
  input logic                    rst,
  matrix_result_collector_if.slave bus
);

  localparam int SEL_W = lane_sel_w(CORE_COUNT);

  state_t                       state;
  logic [CORE_COUNT*DATA_W-1:0] lanes_q;
  logic [4:0]                   row_q;
  logic [4:0]                   col_q;
  logic [SEL_W-1:0]             k_q;
  logic [ADDR_W-1:0]            wr_adr_q;
  logic [DATA_W-1:0]            wr_data_q;
  logic                         done_q;
  logic                         overflow_q;
  logic [15:0]                  count_q;

  logic              strobe;
  logic              accept;
  logic              last_beat;
  logic              final_tile;
  logic              load;
  logic [SEL_W-1:0]  k_next;
  logic [9:0]        beat_end;
  logic [DATA_W-1:0] next_lane;

  always_comb begin
    // A zero-sized matrix makes every strobe meaningless, so it is ignored.
    strobe     = bus.i_results_valid && (bus.i_f_matrix_row_size != 8'd0)
                 && (bus.i_s_matrix_column_size != 8'd0);
    accept     = (state == WRITE) && bus.i_wr_ready;
    k_next     = k_q + 1'b1;
    // The tile ends at its last lane or at the matrix's right edge.
    beat_end   = 10'(col_q) + 10'(k_q) + 10'd1;
    last_beat  = (32'(k_q) == CORE_COUNT - 1)
                 || (beat_end >= 10'(bus.i_s_matrix_column_size));
    final_tile = (8'(row_q) == bus.i_f_matrix_row_size - 8'd1)
                 && ((32'(col_q) + CORE_COUNT) >= 32'(bus.i_s_matrix_column_size));
    // Taking a new tile on the accepted last beat gives back-to-back writes.
    load       = strobe && ((state == IDLE) || (accept && last_beat));
  end

  matrix_lane_select #(
    .CORE_COUNT (CORE_COUNT),
    .DATA_W     (DATA_W),
    .SEL_W      (SEL_W)
  ) u_lane_select (
    .lanes (lanes_q),
    .sel   (k_next),
    .lane  (next_lane)
  );

  // NOTE: tile payload has no reset; it is only read after a strobe loads it.
  always_ff @(posedge CLOCK_25) begin
    if (load) lanes_q <= bus.i_results;
  end

  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      wr_adr_q   <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every test above sees pre-edge state.
      done_q <= 1'b0;
      if (accept) count_q <= count_q + 16'd1;
      if (accept && last_beat) done_q <= final_tile;
      if (strobe && !load) overflow_q <= 1'b1;

      if (load) begin
        state     <= WRITE;
        row_q     <= bus.i_row_adr;
        col_q     <= bus.i_core_column;
        k_q       <= '0;
        wr_adr_q  <= ADDR_W'(tile_base(bus.i_row_adr, bus.i_core_column,
                                       bus.i_s_matrix_column_size));
        wr_data_q <= bus.i_results[DATA_W-1:0];
      end else if (accept) begin
        if (last_beat) begin
          state <= IDLE;
        end else begin
          k_q       <= k_next;
          wr_adr_q  <= wr_adr_q + 1'b1;
          wr_data_q <= next_lane;
        end
      end
    end
  end

`ifdef MATRIX_COLLECT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst)        checksum_q <= '0;
    else if (accept) checksum_q <= checksum_q + wr_data_q;
  end

  assign bus.o_checksum = checksum_q;
`else
  assign bus.o_checksum = '0;
`endif

  assign bus.o_wr_en         = (state == WRITE);
  assign bus.o_busy          = (state == WRITE);
  assign bus.o_wr_adr        = wr_adr_q;
  assign bus.o_wr_data       = wr_data_q;
  assign bus.o_done          = done_q;
  assign bus.o_overflow      = overflow_q;
  assign bus.o_written_count = count_q;

endmodule

// File: doc/matrix_result_collector.md
# matrix_result_collector

Write-back end of the matrix-multiply datapath. Takes the per-core dot-product results produced for one (row, core_column) tile and serializes them into result memory, one element per cycle, behind a ready handshake. The address sequencer drives the cores; this block drains the cores. It tracks completion of the full result matrix and flags lost tiles.

## Interface
- CORE_COUNT, 4, cores per tile; lanes written per tile
- DATA_W, 32, width of one result element
- ADDR_W, 10, result-memory address width
- CLOCK_25  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_f_matrix_row_size  in  8  rows of result matrix
- i_s_matrix_column_size  in  8  columns of result matrix
- i_row_adr  in  5  row of the tile being delivered
- i_core_column  in  5  first result column of the tile
- i_results_valid  in  1  one-cycle strobe: i_results, i_row_adr, i_core_column valid
- i_results  in  CORE_COUNT*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- i_wr_ready  in  1  memory accepts the current write
- o_wr_en  out  1  write request
- o_wr_adr  out  ADDR_W  write address
- o_wr_data  out  DATA_W  write data
- o_busy  out  1  tile held, not yet fully written
- o_done  out  1  one-cycle pulse: last element of matrix accepted
- o_overflow  out  1  sticky: tile strobe dropped
- o_written_count  out  16  elements accepted since reset
- o_checksum  out  DATA_W  running sum of accepted data (feature-dependent)

## Operation
- States: IDLE, WRITE.
- IDLE: o_wr_en=0. On i_results_valid, latch all lanes, row, and core_column. Compute base = row*s_cols + core_column, modulo 2^ADDR_W. Set k=0 and go to WRITE.
- WRITE: o_wr_en=1, o_wr_adr=base+k, o_wr_data=lane k. Address and data hold stable until i_wr_ready is high.
- Beat accepted (o_wr_en & i_wr_ready): o_written_count+1 (wraps at 2^16), k+1.
- Last beat: k==CORE_COUNT-1, or core_column+k+1 >= s_cols. Lanes past the matrix edge are never written.
- After the last beat, go to IDLE, unless a new strobe arrives in the same cycle. In that case latch the new tile and stay in WRITE with k=0, giving back-to-back writes.
- A strobe while in WRITE that is not on an accepted last beat is dropped. It sets o_overflow, and o_overflow clears only on reset.
- o_done: pulses on the accepted last beat of the tile where row == f_rows-1 and core_column+CORE_COUNT >= s_cols.
- s_cols==0 or f_rows==0: strobes are ignored, with no writes and no overflow.
- Reset mid-WRITE: the held tile is discarded and no further writes occur.

## Timing
- Reset values: o_wr_en=0, o_wr_adr=0, o_wr_data=0, o_busy=0, o_done=0, o_overflow=0, o_written_count=0, o_checksum=0, state IDLE.
- All outputs are registered.
- Strobe at edge N gives o_wr_en=1 with k=0 after edge N+1.
- Full tile with ready held high takes CORE_COUNT cycles.
- o_busy equals (state==WRITE).
- o_done asserts the cycle after the final accepting edge, for exactly one cycle.

## Configuration
- MATRIX_COLLECT_CHECKSUM_EN defined: o_checksum += o_wr_data on every accepted beat, DATA_W bits, wrapping.
- Not defined: o_checksum is tied to 0 and no adder is built.

## Structure
- Package matrix_pkg holds:
  - state enum (IDLE, WRITE)
  - default CORE_COUNT and DATA_W
  - address-width localparam shared with the address sequencer
- Sub-module matrix_lane_select: combinational mux selecting lane k from i_results.
- The FSM, address adder, and counters stay in the top module.

## Test plan
- Single tile: s_cols=8, f_rows=4, row=2, core_column=4, lanes {A,B,C,D}, ready high. Expect writes to 20,21,22,23 with A..D on 4 consecutive cycles, then o_wr_en=0, count=4, no o_done.
- Partial edge tile: s_cols=6, row=0, core_column=4. Expect exactly 2 writes (adr 4,5) and lanes 2..3 dropped.
- Backpressure: ready low 3 cycles at beat 1. Expect adr/data held constant; write completes with 3-cycle stall and no overflow.
- Back-to-back and overflow: second strobe on the accepted last beat is written next cycle with no gap. Third strobe mid-tile sets o_overflow sticky and its data is never written.
- Full matrix 2x8, CORE_COUNT=4, four tiles: o_done one pulse after the 16th write, count=16. With the macro defined, o_checksum equals the sum of all data.
- Reset asserted during beat 2: outputs return to reset values immediately. After release, strobes work normally.
